// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the NTT coefficient loader.
package ntt_pkg;
    localparam int COEF_W = 32;
    localparam int DW     = 128;
    localparam int WL     = 32;
    localparam int N_COEF = 128;
    localparam int LANES  = 4;
    localparam int ADDR_W = 13;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } ntt_state_e;
endpackage

// File: rtl/ntt_lane_packer.sv
// Assembles four coefficients into one BRAM line; lanes not yet written in the
// current line read as zero, so a short final line comes out zero-filled.
module ntt_lane_packer #(
    parameter int COEF_W = 32,
    parameter int LANES  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      clear,
    input  logic                      load,
    input  logic [1:0]                lane,
    input  logic [COEF_W-1:0]         data,
    output logic [COEF_W*LANES-1:0]   line
);
    logic [COEF_W*LANES-1:0] line_q;

    // Lane 0 opens a fresh line, discarding the previous line's contents.
    always_comb begin
        line = (lane == 2'd0) ? '0 : line_q;
        line[lane*COEF_W +: COEF_W] = data;
    end

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= line;
        end
    end
endmodule

// File: rtl/ntt_coef_loader.sv
// Loads one 128-coefficient frame from an AXI-style stream into a 32-line BRAM,
// four coefficients per line, and reports framing errors on tlast placement.
module ntt_coef_loader
    import ntt_pkg::*;
#(
    parameter int COEF_W = ntt_pkg::COEF_W,
    parameter int DW     = ntt_pkg::DW,
    parameter int WL     = ntt_pkg::WL
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [COEF_W-1:0] ss_tdata,
    input  logic              ss_tvalid,
    input  logic              ss_tlast,
    output logic              ss_tready,
    output logic              bram_EN,
    output logic [3:0]        bram_WE,
    output logic [12:0]       bram_A,
    output logic [DW-1:0]     bram_Di,
    output logic              busy,
    output logic              done,
    output logic              err,
    output ntt_state_e        state_dbg
);
    localparam int N_BEATS = 4 * WL;
    localparam int CNT_W   = $clog2(N_BEATS);

    ntt_state_e       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [DW-1:0]    packed_line;
    logic             enter_load;
    logic             accept;
    logic             last_beat;
    logic             line_full;
    logic             final_beat;

    // Handshake: a beat transfers on a rising edge where ss_tvalid and ss_tready
    // are both high; ss_tready is a registered copy of "state is LOAD", so the
    // upstream sees it a full cycle before the edge it applies to.
    assign enter_load = start && (state == S_IDLE || state == S_DONE);
    assign accept     = ss_tvalid && ss_tready && (state == S_LOAD);
    assign last_beat  = (beat_cnt == CNT_W'(N_BEATS - 1));
    assign line_full  = (beat_cnt[1:0] == 2'd3);
    assign final_beat = ss_tlast || last_beat;
    assign state_dbg  = state;

    ntt_lane_packer #(
        .COEF_W (COEF_W),
        .LANES  (4)
    ) u_packer (
        .CLK   (CLK),
        .RST   (RST),
        .clear (enter_load),
        .load  (accept),
        .lane  (beat_cnt[1:0]),
        .data  (ss_tdata),
        .line  (packed_line)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            ss_tready <= 1'b0;
            bram_EN   <= 1'b0;
            bram_WE   <= 4'h0;
            bram_A    <= '0;
            bram_Di   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            bram_EN <= 1'b0;
            bram_WE <= 4'h0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        beat_cnt  <= '0;
                        ss_tready <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (line_full || final_beat) begin
                            bram_EN <= 1'b1;
                            bram_WE <= 4'hF;
                            bram_A  <= 13'({beat_cnt[CNT_W-1:2], 2'b00});
                            bram_Di <= packed_line;
                        end
                        // Either tlast or the 128th beat closes the frame.
                        if (final_beat) begin
                            state     <= S_FLUSH;
                            ss_tready <= 1'b0;
                            err       <= !(ss_tlast && last_beat);
                        end
                    end
                end
                S_FLUSH: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_coef_loader.sv
// Directed bench for ntt_coef_loader: a frame-level model predicts each cycle's
// handshake, status and BRAM writes, and a shadow BRAM is compared per frame.
module tb_ntt_coef_loader;
    import ntt_pkg::*;

    localparam int CW = 32;
    localparam int LW = 128;
    localparam int NL = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] ss_tdata;
    logic          ss_tvalid;
    logic          ss_tlast;
    logic          ss_tready;
    logic          bram_EN;
    logic [3:0]    bram_WE;
    logic [12:0]   bram_A;
    logic [LW-1:0] bram_Di;
    logic          busy;
    logic          done;
    logic          err;
    ntt_state_e    state_dbg;

    ntt_coef_loader dut (
        .CLK       (clk),
        .RST       (rst),
        .start     (start),
        .ss_tdata  (ss_tdata),
        .ss_tvalid (ss_tvalid),
        .ss_tlast  (ss_tlast),
        .ss_tready (ss_tready),
        .bram_EN   (bram_EN),
        .bram_WE   (bram_WE),
        .bram_A    (bram_A),
        .bram_Di   (bram_Di),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model expectations for the cycle after the next rising edge
    logic exp_ready, exp_busy, exp_done, exp_err, exp_en, flush_pend;
    logic [LW-1:0]      line_buf;
    logic [LW+12:0]     exp_q[$];
    logic [LW-1:0]      exp_mem [NL];
    logic [LW-1:0]      cap_mem [NL];
    logic [LW-1:0]      sentinel;
    logic [LW+12:0]     exp_word;
    logic               chk_on = 1'b0;
    logic               spacing_on = 1'b0;
    int                 n_wr;
    int                 n_exp_wr;
    int                 cyc = 0;
    int                 last_wr_cyc;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // scoreboard: compares every cycle, 1 time unit after the rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (chk_on) begin
                chk("tready", 256'(ss_tready), 256'(exp_ready));
                chk("busy",   256'(busy),      256'(exp_busy));
                chk("done",   256'(done),      256'(exp_done));
                chk("err",    256'(err),       256'(exp_err));
                chk("en",     256'(bram_EN),   256'(exp_en));
                chk("we",     256'(bram_WE),   256'(exp_en ? 4'hF : 4'h0));
                if (bram_EN) begin
                    n_wr++;
                    cap_mem[bram_A[7:2]] = bram_Di;
                    if (spacing_on && last_wr_cyc >= 0)
                        chk("wr_spacing", 256'(cyc - last_wr_cyc), 256'(8));
                    last_wr_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_wr", 256'(1), 256'(0));
                    end else begin
                        exp_word = exp_q.pop_front();
                        chk("addr", 256'(bram_A),  256'(exp_word[LW+12:LW]));
                        chk("data", 256'(bram_Di), 256'(exp_word[LW-1:0]));
                    end
                end
            end
        end
    end

    // one negedge step; expectations written here describe the state after the next edge
    task automatic tick();
        @(negedge clk);
        exp_en = 1'b0;
        if (flush_pend) begin
            exp_busy   = 1'b0;
            exp_done   = 1'b1;
            flush_pend = 1'b0;
        end
    endtask

    task automatic model_accept(input int k, input logic [CW-1:0] d, input logic is_last);
        int lane;
        lane = k % 4;
        line_buf[lane*CW +: CW] = d;
        if (lane == 3 || is_last || k == 127) begin
            exp_en = 1'b1;
            exp_q.push_back({13'((k / 4) * 4), line_buf});
            exp_mem[k / 4] = line_buf;
            line_buf = '0;
            n_exp_wr++;
        end
        if (is_last || k == 127) begin
            exp_ready  = 1'b0;
            exp_err    = !(is_last && k == 127);
            flush_pend = 1'b1;
        end
    endtask

    task automatic new_test(input logic spacing);
        n_wr        = 0;
        n_exp_wr    = 0;
        last_wr_cyc = -1;
        spacing_on  = spacing;
        for (int i = 0; i < NL; i++) begin
            cap_mem[i] = sentinel;
            exp_mem[i] = sentinel;
        end
    endtask

    task automatic pulse_start();
        tick();
        start     = 1'b1;
        exp_ready = 1'b1;
        exp_busy  = 1'b1;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        line_buf  = '0;
        tick();
        start = 1'b0;
    endtask

    // drive beats k = 0.. until nbeats taken (or stop_at reached); tdata = k + base
    task automatic send_frame(input int nbeats, input int last_idx, input logic toggle,
                              input int stop_at, input int start_at, input int base);
        int  k;
        int  c;
        logic started;
        k = 0;
        c = 0;
        started = 1'b0;
        while (k < nbeats && k != stop_at) begin
            tick();
            ss_tvalid = toggle ? (c % 2 == 0) : 1'b1;
            ss_tdata  = CW'(k + base);
            ss_tlast  = (k == last_idx);
            start     = (k == start_at) && !started;
            if (k == start_at) started = 1'b1;
            c++;
            if (c > 2000) begin
                chk("frame_timeout", 256'(k), 256'(nbeats));
                break;
            end
            if (ss_tvalid && ss_tready)
                model_accept(k, ss_tdata, ss_tlast);
            if (ss_tvalid && ss_tready) k++;
        end
        tick();
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        start     = 1'b0;
    endtask

    task automatic end_frame(input string name);
        repeat (3) tick();
        chk({name, "_nwr"},   256'(n_wr), 256'(n_exp_wr));
        chk({name, "_qleft"}, 256'(exp_q.size()), 256'(0));
        for (int i = 0; i < NL; i++)
            chk({name, "_line"}, 256'(cap_mem[i]), 256'(exp_mem[i]));
    endtask

    initial begin
        sentinel   = {LW{1'b1}};
        rst        = 1'b1;
        start      = 1'b0;
        ss_tdata   = '0;
        ss_tvalid  = 1'b0;
        ss_tlast   = 1'b0;
        exp_ready  = 1'b0;
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        exp_en     = 1'b0;
        flush_pend = 1'b0;
        line_buf   = '0;
        new_test(1'b0);

        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_A",  256'(bram_A),  256'(0));
        chk("rst_Di", 256'(bram_Di), 256'(0));
        rst = 1'b0;

        // full frame, continuous valid, tlast on beat 127
        new_test(1'b0);
        pulse_start();
        send_frame(128, 127, 1'b0, -1, -1, 0);
        end_frame("full");
        chk("full_line0_lit", 256'(cap_mem[0]), 256'({32'd3, 32'd2, 32'd1, 32'd0}));
        chk("full_nwr_lit",   256'(n_wr), 256'(32));
        chk("full_done_err",  256'({done, err}), 256'(2'b10));

        // same frame with valid toggling each cycle
        new_test(1'b1);
        pulse_start();
        send_frame(128, 127, 1'b1, -1, -1, 0);
        end_frame("toggle");
        chk("toggle_line31_lit", 256'(cap_mem[31]), 256'({32'd127, 32'd126, 32'd125, 32'd124}));

        // early tlast on beat 5
        new_test(1'b0);
        pulse_start();
        send_frame(6, 5, 1'b0, -1, -1, 0);
        end_frame("short");
        chk("short_line1_lit", 256'(cap_mem[1]), 256'({64'd0, 32'd5, 32'd4}));
        chk("short_line2_untouched", 256'(cap_mem[2]), 256'(sentinel));
        chk("short_done_err", 256'({done, err}), 256'(2'b11));

        // 128 beats without tlast, then keep offering beats
        new_test(1'b0);
        pulse_start();
        send_frame(128, -1, 1'b0, -1, -1, 0);
        ss_tvalid = 1'b1;
        ss_tdata  = 32'd999;
        repeat (4) tick();
        ss_tvalid = 1'b0;
        end_frame("nolast");
        chk("nolast_done_err", 256'({done, err}), 256'(2'b11));

        // reset after beat 61, then a fresh full frame
        new_test(1'b0);
        pulse_start();
        send_frame(128, 127, 1'b0, 62, -1, 0);
        rst        = 1'b1;
        exp_ready  = 1'b0;
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        flush_pend = 1'b0;
        tick();
        chk("rst_mid_A",  256'(bram_A),  256'(0));
        chk("rst_mid_Di", 256'(bram_Di), 256'(0));
        chk("rst_mid_q",  256'(exp_q.size()), 256'(0));
        rst = 1'b0;
        tick();
        new_test(1'b0);
        pulse_start();
        send_frame(128, 127, 1'b0, -1, -1, 1000);
        end_frame("after_rst");
        chk("after_rst_line0_lit", 256'(cap_mem[0]), 256'({32'd1003, 32'd1002, 32'd1001, 32'd1000}));

        // stray start in the middle of LOAD is ignored
        new_test(1'b0);
        pulse_start();
        send_frame(128, 127, 1'b0, -1, 40, 500);
        end_frame("stray_start");
        chk("stray_done_err", 256'({done, err}), 256'(2'b10));

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ntt_coef_loader.md
NTT_COEF_LOADER -- requirements
Module: ntt_coef_loader

Interface
REQ-001 Parameter COEF_W, default 32: coefficient width in bits.
REQ-002 Parameter DW, default 128: BRAM line width; 4 coefficients per line.
REQ-003 Parameter WL, default 32: BRAM lines per frame; frame = 4*WL = 128 coefficients.
REQ-004 CLK  in  1  sole clock; all logic on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse that arms loading of one frame.
REQ-007 ss_tdata  in  COEF_W  coefficient from the upstream stream.
REQ-008 ss_tvalid  in  1  upstream data valid.
REQ-009 ss_tlast  in  1  marks the final coefficient of the frame.
REQ-010 ss_tready  out  1  loader accepts a beat.
REQ-011 bram_EN  out  1  BRAM enable, to the coefficient bram32x128 EN.
REQ-012 bram_WE  out  4  BRAM write strobe, 4'hF on a write, else 4'h0.
REQ-013 bram_A  out  13  BRAM byte address, line index << 2.
REQ-014 bram_Di  out  DW  packed line.
REQ-015 busy  out  1  high in LOAD or FLUSH.
REQ-016 done  out  1  high in DONE, held until next start or RST.
REQ-017 err  out  1  framing error of the last frame, valid while done=1.

Function
REQ-018 FSM states: IDLE, LOAD, FLUSH, DONE.
REQ-019 IDLE -> LOAD on start; DONE -> LOAD on start; start in LOAD/FLUSH is ignored.
REQ-020 Entering LOAD clears the beat counter (0..127), the lane register, err and done.
REQ-021 ss_tready = 1 only in LOAD; a beat is accepted when ss_tvalid & ss_tready.
REQ-022 Beat k goes to line k/4, lane k%4, at bits [32*(k%4)+31 : 32*(k%4)] of bram_Di.
REQ-023 Acceptance of lane 3 registers a write: next cycle bram_EN=1, bram_WE=4'hF, bram_A=(k/4)<<2, bram_Di = full line.
REQ-024 Write strobe lasts exactly one cycle per line; bram_EN=0, bram_WE=0 on all other cycles.
REQ-025 ss_tready stays 1 through line boundaries; back-to-back beats sustain 1 coefficient per cycle with no bubbles.
REQ-026 Beat 127 with ss_tlast=1 -> FLUSH (final write issued), then DONE with err=0.
REQ-027 Beat 127 with ss_tlast=0 -> same path, err=1; subsequent stream beats are not accepted.
REQ-028 ss_tlast=1 on beat k<127 -> partial line written with unfilled lanes zero, then DONE with err=1; lines above k/4 untouched.
REQ-029 FLUSH lasts exactly one cycle (the final write cycle); DONE entered the cycle after.
REQ-030 bram_A never exceeds (WL-1)<<2 = 124; address wrap is impossible by construction.
REQ-031 ss_tvalid=0 stalls LOAD indefinitely; counters and lane register hold.

Reset
REQ-032 RST=1 at any edge forces IDLE, counters and lane register to 0.
REQ-033 Reset values: ss_tready=0, bram_EN=0, bram_WE=0, bram_A=0, bram_Di=0, busy=0, done=0, err=0.
REQ-034 RST during LOAD/FLUSH drops any pending write; no strobe is issued in the cycle after RST.

Structure
REQ-035 Shared package ntt_pkg holds COEF_W, DW, WL, N_COEF=128 and the FSM state enum.
REQ-036 One sub-module, ntt_lane_packer: lane shift register plus zero-fill of unfilled lanes; FSM and counters stay in the top.
REQ-037 All outputs registered; no combinational path from ss_tvalid to bram_* outputs.

Verification
REQ-038 start, 128 beats tdata=k, tvalid continuous, tlast on beat 127 -> 32 writes, line 0 = {32'd3,32'd2,32'd1,32'd0}, A=0..124 step 4, done=1, err=0.
REQ-039 Same frame with tvalid toggling 1/0 each cycle -> identical BRAM contents; writes spaced by 8 cycles.
REQ-040 tlast on beat 5 (tdata=k) -> 2 writes, line 1 = {64'd0,32'd5,32'd4}, done=1, err=1.
REQ-041 128 beats, no tlast -> 32 writes, err=1, ss_tready=0 after beat 127.
REQ-042 RST after beat 61 -> no further strobes, all outputs 0; a new start + full frame loads correctly.
REQ-043 start pulse during LOAD -> ignored, counters unchanged, frame completes normally.
